next_pc_btb: RTL
================

# next_pc_btb

Next-PC generation stage directly upstream of the program-counter register. Each cycle it looks up the current fetch PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and drives the predicted next PC into the PC register's input. It accepts resolved-branch updates from the execute stage and detects mispredictions. On a misprediction it redirects fetch, flushes IF/ID and overrides the hazard stall.

## Interface
Parameters:
- ENTRIES, 16, number of BTB entries; power of two.
- IDX_W, 4, log2(ENTRIES); index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- pc_i  in  32  current fetch PC (PC register output).
- stall_i  in  1  load-use hazard stall request from hazard detection.
- upd_valid_i  in  1  a branch/jump resolved this cycle.
- upd_pc_i  in  32  PC of the resolved branch.
- upd_taken_i  in  1  actual outcome.
- upd_target_i  in  32  actual taken target.
- upd_pred_taken_i  in  1  prediction made for this branch, carried down the pipeline.
- upd_pred_target_i  in  32  predicted target, carried down the pipeline.
- pc_o  out  32  next PC, fed to the PC register input.
- pc_hold_o  out  1  hold request, fed to the PC register's hazard input.
- pred_taken_o  out  1  prediction for pc_i, to be carried with the instruction.
- pred_target_o  out  32  predicted target for pc_i (0 when not taken).
- flush_o  out  1  squash IF/ID (wrong-path instruction).

## Operation
- Entry state: valid (1), tag (30-IDX_W), target[31:2] (30), ctr (2).
- Lookup (combinational on pc_i):
  - hit = valid[idx] & (tag[idx] == pc_i tag).
  - pred_taken_o = hit & ctr[1].
  - pred_target_o = pred_taken_o ? {target,2'b00} : 0.
- Misprediction is evaluated only when upd_valid_i=1:
  - mispredict = (upd_taken_i != upd_pred_taken_i) | (upd_taken_i & upd_pred_target_i != upd_target_i).
  - redirect_pc = upd_taken_i ? upd_target_i : upd_pc_i + 4.
- pc_o priority, highest first:
  1. mispredict: pc_o = redirect_pc.
  2. pred_taken_o: pc_o = pred_target_o.
  3. otherwise: pc_o = pc_i + 4.
- flush_o = mispredict.
- pc_hold_o = stall_i & ~mispredict. The redirect belongs to an older instruction, so it wins over the stall.
- Update on upd_valid_i, at the entry indexed by upd_pc_i:
  - Hit, taken: ctr saturating-increments (max 2'b11); target and tag rewritten.
  - Hit, not taken: ctr saturating-decrements (min 2'b00); target unchanged.
  - Miss, taken: allocate. valid=1, tag/target written, ctr=2'b10 (weakly taken). Overwrites any existing occupant.
  - Miss, not taken: no change.
- Updates are applied regardless of stall_i.
- Arithmetic:
  - +4 wraps modulo 2^32: 0xFFFFFFFC gives 0x00000000.
  - pc[1:0] are ignored for indexing and tagging.
  - pc_o[1:0] is forced to 00.

## Timing
- Lookup, pc_o, flush_o and pc_hold_o are combinational; zero-cycle latency. The PC register captures pc_o at the next edge.
- Table writes take effect at the rising edge after upd_valid_i. A same-cycle lookup of the same index sees the pre-update contents; no bypass.
- Reset, rst_i high at an edge:
  - all valid cleared; all ctr set to 2'b01; tags and targets don't-care.
  - During reset cycles, flush_o=0, pc_hold_o=0, pred_taken_o=0, pred_target_o=0, pc_o=pc_i+4.
  - Updates presented during reset are discarded.
- Reset asserted mid-operation discards any in-flight update that cycle. Training restarts from an empty table.
- Simultaneous mispredict and stall_i: flush_o=1, pc_hold_o=0, pc_o=redirect_pc.
- Simultaneous mispredict and a BTB hit on pc_i: the redirect wins, and pred_taken_o still reflects the lookup.

## Test plan
- Reset then sequential fetch:
  - Stimulus: pc_i=0x00000000..0x0000000C, no updates.
  - Required: pc_o=pc_i+4, pred_taken_o=0, flush_o=0 every cycle.
- Cold taken branch:
  - Stimulus: upd_valid_i, upd_pc_i=0x40, upd_taken_i=1, upd_target_i=0x100, pred_taken=0.
  - Required same cycle: flush_o=1, pc_o=0x100.
  - Required next cycle: pc_i=0x40 gives pred_taken_o=1, pc_o=0x100.
- Counter saturation:
  - Stimulus: from ctr=2'b10, three taken updates at 0x40, then two not-taken.
  - Required: still predicts taken after the first not-taken (2'b10); predicts not-taken after the second (2'b01).
  - Required: both not-taken updates flag mispredict only when the prediction they carry was taken.
- Alias and wrap:
  - Stimulus: allocate 0x40, then taken update at 0x80 (same idx for ENTRIES=16).
  - Required: lookup at 0x40 now misses.
  - Stimulus: separately, pc_i=0xFFFFFFFC with no hit.
  - Required: pc_o=0x00000000.
- Redirect vs stall:
  - Stimulus: stall_i=1 with mispredict (upd_pc_i=0x20, taken=0, pred_taken=1).
  - Required: pc_hold_o=0, flush_o=1, pc_o=0x24.
  - Stimulus: stall_i=1 with no update.
  - Required: pc_hold_o=1.
- Reset mid-update:
  - Stimulus: rst_i=1 together with a taken update at 0x40.
  - Required: after reset, pc_i=0x40 gives pred_taken_o=0, flush_o stays 0 during reset.

Source files
------------

// File: rtl/next_pc_btb.sv
// Next-PC generation with a direct-mapped BTB and 2-bit counters.
// It also detects mispredictions on resolved branches and redirects fetch.
module next_pc_btb #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_pred_taken_i,
  input  logic [31:0] upd_pred_target_i,
  output logic [31:0] pc_o,
  output logic        pc_hold_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  output logic        flush_o
);

  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0]            valid_q;
  logic [ENTRIES-1:0][1:0]       ctr_q;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q;
  logic [ENTRIES-1:0][29:0]      tgt_q;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             upd_en;
  logic             mispredict;
  logic [31:0]      redirect_pc;
  logic [31:0]      seq_pc;
  logic [31:0]      next_pc;
  logic [1:0]       ctr_d;
  logic             wr_ctr;
  logic             wr_entry;

  assign lk_idx = pc_i[IDX_W+1:2];
  assign lk_tag = pc_i[31:IDX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  // Reset masks the prediction so nothing stale leaks out during reset.
  assign pred_taken_o  = lk_hit && ctr_q[lk_idx][1] && !rst_i;
  assign pred_target_o = pred_taken_o ? {tgt_q[lk_idx], 2'b00} : 32'h0;

  assign upd_en      = upd_valid_i && !rst_i;
  assign mispredict  = upd_en && ((upd_taken_i != upd_pred_taken_i) ||
                       (upd_taken_i && (upd_pred_target_i != upd_target_i)));
  assign redirect_pc = upd_taken_i ? upd_target_i : (upd_pc_i + 32'd4);
  assign seq_pc      = pc_i + 32'd4;

  always_comb begin
    next_pc = seq_pc;
    if (mispredict) begin
      next_pc = redirect_pc;
    end else if (pred_taken_o) begin
      next_pc = pred_target_o;
    end
  end

  assign pc_o      = {next_pc[31:2], 2'b00};
  assign flush_o   = mispredict;
  assign pc_hold_o = stall_i && !mispredict && !rst_i;

  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[31:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    ctr_d    = ctr_q[up_idx];
    wr_ctr   = 1'b0;
    wr_entry = 1'b0;
    if (upd_en) begin
      if (up_hit) begin
        wr_ctr = 1'b1;
        if (upd_taken_i) begin
          wr_entry = 1'b1;
          ctr_d    = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'b01;
        end else begin
          ctr_d    = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'b01;
        end
      end else if (upd_taken_i) begin
        // Allocation evicts whatever aliased into this slot.
        wr_ctr   = 1'b1;
        wr_entry = 1'b1;
        ctr_d    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      ctr_q   <= {ENTRIES{2'b01}};
    end else begin
      if (wr_ctr) begin
        ctr_q[up_idx] <= ctr_d;
      end
      if (wr_entry) begin
        valid_q[up_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_entry) begin
      tag_q[up_idx] <= up_tag;
      tgt_q[up_idx] <= upd_target_i[31:2];
    end
  end

endmodule
